// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard/forwarding unit: select encoding and
// the per-stage scoreboard entry describing one in-flight register write.
package hazard_pkg;

  // Operand select value meaning "take the register file read".
  localparam int FWD_RF = 0;

  // Widest register address a scoreboard entry can hold; narrower addresses are zero-extended.
  localparam int SB_AW_MAX = 8;

  typedef struct packed {
    logic                 v;
    logic [SB_AW_MAX-1:0] wa;
    logic                 ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Priority matcher for one source operand against the in-flight write scoreboard:
// youngest matching stage wins, and a load there flags a load-use hazard.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FSW        = 2
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_use,
  input  sb_entry_t         sb [1:FWD_STAGES],
  output logic [FSW-1:0]    sel,
  output logic              load_hit
);

  always_comb begin
    // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
    sel      = FSW'(FWD_RF);
    load_hit = 1'b0;
    if (src_use && (src != '0)) begin
      // Walk oldest to youngest so the last hit, the youngest, is the one kept.
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (sb[k].v && (sb[k].wa == SB_AW_MAX'(src))) begin
          sel      = FSW'(k);
          load_hit = sb[k].ld && (k < LOAD_STAGE);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard and forwarding unit beside ID: tracks in-flight writes,
// drives operand forwarding selects, load-use and MULT/DIV stalls, and ID squash.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_LAT     = 4,
  localparam int FSW       = $clog2(FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic              id_wrf,
  input  logic [REG_AW-1:0] id_wa,
  input  logic              id_load,
  input  logic              id_md_start,
  input  logic              id_hilo_use,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [FSW-1:0]    rd1c,
  output logic [FSW-1:0]    rd2c,
  output logic              md_busy
);

  localparam int MDW = $clog2(MD_LAT + 1);

  sb_entry_t        sb_q [1:FWD_STAGES];
  sb_entry_t        sb_d [1:FWD_STAGES];
  logic [MDW-1:0]   md_cnt_q;
  logic [MDW-1:0]   md_cnt_d;
  logic             rs_ld_hit;
  logic             rt_ld_hit;
  logic             load_use;
  logic             md_stall;

  hazard_src_match #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .LOAD_STAGE(LOAD_STAGE),
    .FSW       (FSW)
  ) u_rs_match (
    .src     (id_rs),
    .src_use (id_rs_use),
    .sb      (sb_q),
    .sel     (rd1c),
    .load_hit(rs_ld_hit)
  );

  hazard_src_match #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .LOAD_STAGE(LOAD_STAGE),
    .FSW       (FSW)
  ) u_rt_match (
    .src     (id_rt),
    .src_use (id_rt_use),
    .sb      (sb_q),
    .sel     (rd2c),
    .load_hit(rt_ld_hit)
  );

  assign md_busy  = (md_cnt_q != '0);
  assign load_use = rs_ld_hit | rt_ld_hit;
  assign md_stall = md_busy & (id_md_start | id_hilo_use);
  // flush wins over any stall: a squashed instruction never holds the front end.
  assign stall    = id_valid & ~flush & (load_use | md_stall);
  assign issue    = id_valid & ~flush & ~stall;

  always_comb begin
    sb_d[1].v  = issue & id_wrf & (id_wa != '0);
    sb_d[1].wa = SB_AW_MAX'(id_wa);
    sb_d[1].ld = id_load;
    for (int k = 2; k <= FWD_STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end

    // The busy counter keeps running while ID is stalled.
    md_cnt_d = md_cnt_q;
    if (issue && id_md_start) begin
      md_cnt_d = MDW'(MD_LAT);
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every scoreboard entry is reset; a stale valid bit would forward garbage after reset.
      for (int k = 1; k <= FWD_STAGES; k++) begin
        sb_q[k] <= '0;
      end
      md_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
      sb_q     <= sb_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic,
// checked against a history-of-issued-instructions reference model.
module tb_hazard_scoreboard;

  localparam int REG_AW     = 5;
  localparam int FWD_STAGES = 3;
  localparam int LOAD_STAGE = 2;
  localparam int MD_LAT     = 4;
  localparam int FSW        = $clog2(FWD_STAGES + 1);
  localparam int HIST       = 4096;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_use;
  logic              id_rt_use;
  logic              id_wrf;
  logic [REG_AW-1:0] id_wa;
  logic              id_load;
  logic              id_md_start;
  logic              id_hilo_use;
  logic              flush;
  logic              stall;
  logic              issue;
  logic [FSW-1:0]    rd1c;
  logic [FSW-1:0]    rd2c;
  logic              md_busy;

  hazard_scoreboard #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .LOAD_STAGE(LOAD_STAGE),
    .MD_LAT    (MD_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_use  (id_rs_use),
    .id_rt_use  (id_rt_use),
    .id_wrf     (id_wrf),
    .id_wa      (id_wa),
    .id_load    (id_load),
    .id_md_start(id_md_start),
    .id_hilo_use(id_hilo_use),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .rd1c       (rd1c),
    .rd2c       (rd2c),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what issued in each cycle. Stage k in cycle t holds cycle t-k's instruction.
  bit hv  [0:HIST-1];
  int hwa [0:HIST-1];
  bit hld [0:HIST-1];
  int t         = 0;
  int reset_cyc = 0;
  int last_md   = -1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input bit wrf, input int wa, input bit ld, input bit md, input bit hilo,
                       input bit fl);
    id_valid    = v;
    id_rs       = REG_AW'(rs);
    id_rs_use   = rsu;
    id_rt       = REG_AW'(rt);
    id_rt_use   = rtu;
    id_wrf      = wrf;
    id_wa       = REG_AW'(wa);
    id_load     = ld;
    id_md_start = md;
    id_hilo_use = hilo;
    flush       = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic void model_src(input int x, input bit use_x, output int sel, output bit ld_hit);
    sel    = 0;
    ld_hit = 1'b0;
    if (use_x && x != 0) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        int c;
        c = t - k;
        if (c >= reset_cyc && c >= 0 && hv[c] && hwa[c] == x) begin
          sel    = k;
          ld_hit = hld[c] && (k < LOAD_STAGE);
          break;
        end
      end
    end
  endfunction

  // Compare all outputs against the model at mid-cycle, then log this cycle's issue.
  task automatic eval_cycle();
    int s1, s2;
    bit l1, l2, mb, es, ei;
    @(negedge clk);
    model_src(int'(id_rs), id_rs_use, s1, l1);
    model_src(int'(id_rt), id_rt_use, s2, l2);
    mb = (last_md >= reset_cyc) && (t - last_md >= 1) && (t - last_md <= MD_LAT);
    es = id_valid && !flush && (l1 || l2 || (mb && (id_md_start || id_hilo_use)));
    ei = id_valid && !flush && !es;
    check("stall", 32'(stall), 32'(es));
    check("issue", 32'(issue), 32'(ei));
    check("md_busy", 32'(md_busy), 32'(mb));
    if (!es) begin
      check("rd1c", 32'(rd1c), 32'(s1));
      check("rd2c", 32'(rd2c), 32'(s2));
    end
    hv[t]  = ei && id_wrf && (id_wa != '0);
    hwa[t] = int'(id_wa);
    hld[t] = id_load;
    if (ei && id_md_start) last_md = t;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic step();
    eval_cycle();
    advance();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 3, 1, 4, 1, 1, 5, 0, 0, 0, 0);
    #3;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_issue", 32'(issue), 32'd1);
    check("rst_rd1c", 32'(rd1c), 32'd0);
    check("rst_rd2c", 32'(rd2c), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    #4;
    rst_n = 1'b1;
    nop();

    // ALU forwarding chain: $3 walks through stages 1, 2, 3 then retires to the RF.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= FWD_STAGES + 1; k++) begin
      eval_cycle();
      check("alu_chain", 32'(rd1c), (k <= FWD_STAGES) ? k : 0);
      advance();
    end

    // Load-use: one bubble, then both operands from stage 2.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0); step();
    drive(1, 5, 1, 5, 1, 1, 6, 0, 0, 0, 0);
    eval_cycle();
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_issue", 32'(issue), 32'd0);
    advance();
    eval_cycle();
    check("lu_rd1c", 32'(rd1c), 32'd2);
    check("lu_rd2c", 32'(rd2c), 32'd2);
    check("lu_issue2", 32'(issue), 32'd1);
    advance();

    // Youngest wins across duplicate destinations; $0 is never tracked.
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0); step();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    eval_cycle();
    check("young_rd2c", 32'(rd2c), 32'd1);
    advance();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    eval_cycle();
    check("zero_rd1c", 32'(rd1c), 32'd0);
    check("zero_stall", 32'(stall), 32'd0);
    advance();

    // MULT then mflo after a gap: stalls while md_cnt counts 3, 2, 1.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    nop(); step();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      check("md_hilo_stall", 32'(stall), 32'd1);
      advance();
    end
    eval_cycle();
    check("md_hilo_issue", 32'(issue), 32'd1);
    advance();

    // Back-to-back MULT presented at md_cnt=1 waits exactly one cycle.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    nop(); step(); step(); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    eval_cycle();
    check("md_b2b_stall", 32'(stall), 32'd1);
    advance();
    eval_cycle();
    check("md_b2b_issue", 32'(issue), 32'd1);
    advance();
    nop();
    for (int i = 0; i <= MD_LAT; i++) step();

    // Flush during a would-be load-use stall: no stall, no issue, bubble enters.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0); step();
    drive(1, 5, 1, 5, 1, 1, 6, 0, 0, 0, 1);
    eval_cycle();
    check("fl_stall", 32'(stall), 32'd0);
    check("fl_issue", 32'(issue), 32'd0);
    advance();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    eval_cycle();
    check("fl_bubble_rd1c", 32'(rd1c), 32'd2);
    advance();

    // Asynchronous reset with md_cnt=3 and a full scoreboard.
    drive(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 11, 0, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0); step();
    drive(1, 12, 1, 11, 1, 0, 0, 0, 0, 1, 0);
    #1;
    check("pre_rst_md_busy", 32'(md_busy), 32'd1);
    check("pre_rst_rd1c", 32'(rd1c), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_md_busy", 32'(md_busy), 32'd0);
    check("mid_rst_rd1c", 32'(rd1c), 32'd0);
    check("mid_rst_rd2c", 32'(rd2c), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    #1;
    rst_n = 1'b1;
    reset_cyc = t;
    step();

    // Random traffic over a small register set to provoke frequent hits.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 85,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 99) < 70, $urandom_range(0, 7),
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
